axi_llc_ax_splitter: RTL and testbench
======================================

Name: axi_llc_ax_splitter

Overview:
- Sequential Ax-channel splitter in the LLC front end; one instance on AW (write) and one on AR (read).
- Accepts one AXI AW/AR transaction at a time and registers it.
- Emits a stream of per-cache-line descriptors, one per clock on valid/ready handshake.
- Feeds the descriptor stage that does tag lookup and SPM steering.

Parameters:
- AddrWidth, 64, Ax address width in bits.
- IdWidth, 6, AXI ID width.
- UserWidth, 4, AXI user width; carries the partition ID.
- LineOffset, 7, log2 of cache-line size in bytes (ByteOffsetLength + BlockOffsetLength).
- Write, 1'b0, value driven on desc_rw_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active high.
- ax_valid_i  in  1  Ax transaction valid.
- ax_ready_o  out  1  Ax transaction accepted.
- ax_id_i  in  IdWidth  AXI ID.
- ax_addr_i  in  AddrWidth  start address.
- ax_len_i  in  8  AXI len (beats-1).
- ax_size_i  in  3  AXI size.
- ax_burst_i  in  2  AXI burst type.
- ax_user_i  in  UserWidth  partition ID.
- desc_valid_o  out  1  descriptor valid.
- desc_ready_i  in  1  descriptor accepted.
- desc_id_o  out  IdWidth  copied from ax_id_i.
- desc_addr_o  out  AddrWidth  first byte address of this descriptor.
- desc_len_o  out  8  beats-1 on this line.
- desc_size_o  out  3  copied from ax_size_i.
- desc_burst_o  out  2  copied from ax_burst_i.
- desc_user_o  out  UserWidth  copied from ax_user_i.
- desc_rw_o  out  1  equals Write.
- desc_first_o  out  1  first descriptor of the transaction.
- desc_last_o  out  1  last descriptor of the transaction.
- busy_o  out  1  a transaction is held.

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset values: state IDLE; desc_valid_o=0; ax_ready_o=1; busy_o=0; all registered fields and descriptor data outputs 0.
- States:
  - IDLE: ax_ready_o=1, desc_valid_o=0.
  - SPLIT: desc_valid_o=1, busy_o=1.
- IDLE->SPLIT when ax_valid_i and ax_ready_o. Capture all Ax fields into cur_* registers and set first_q=1.
- Latency: the first descriptor is valid the cycle after Ax acceptance. After that, one descriptor per cycle while desc_ready_i=1.
- Combinational split on the cur registers:
  - bytes_on_line = 2^LineOffset - cur_addr[LineOffset-1:0], computed in LineOffset+1 bits.
  - beats_on_line = ((bytes_on_line-1) >> cur_size) + 1, computed 9 bits wide.
  - last = (cur_burst != INCR) or ((beats_on_line-1) >= cur_len).
  - FIXED and WRAP are never split; each produces one descriptor with len = cur_len.
- Descriptor outputs:
  - desc_addr_o = cur_addr.
  - desc_len_o = last ? cur_len : beats_on_line-1.
  - desc_first_o = first_q.
  - desc_last_o = last.
- On a handshake (desc_valid_o & desc_ready_i) with last=0:
  - cur_addr <= (cur_addr >> LineOffset << LineOffset) + 2^LineOffset.
  - cur_len <= cur_len - beats_on_line.
  - first_q <= 0.
  - Stay in SPLIT.
- On a handshake with last=1:
  - ax_ready_o=1 in the same cycle (combinational: IDLE | (SPLIT & handshake & last)).
  - If ax_valid_i is also high, capture the new Ax and stay in SPLIT with first_q=1. Back-to-back transactions have zero bubble.
  - Otherwise go to IDLE.
- Stall (desc_valid_o=1, desc_ready_i=0): all desc_* outputs hold stable; ax_ready_o=0.
- Address sizing:
  - Arithmetic is AddrWidth wide. No wrap past the top of the address space for INCR; such a transaction violates the AXI 4 KiB rule.
  - Simulation assertion (translate_off): next line address > cur_addr whenever last=0.
- ax_size_i larger than the bus width is not checked; it is passed through.
- Reset mid-operation: the held transaction and any pending descriptors are dropped; return to IDLE next cycle.
- AXI stability: desc_valid_o never drops without a handshake.

Decomposition:
- Shared package axi_llc_pkg holds:
  - the burst encodings (BURST_FIXED/INCR/WRAP from axi_pkg);
  - the descriptor field widths;
  - a typedef ax_split_desc_t bundling the desc_* fields.
- Sub-module axi_llc_line_split: purely combinational; (addr, len, size, burst) -> (desc_len, next_addr, next_len, last).
- FSM and registers live in the top module.

Test Plan (LineOffset=7, size=3):
- Line crossing: addr=0x1F0, len=31, INCR -> three descriptors:
  - (0x1F0, len 1, first=1, last=0);
  - (0x200, len 15, first=0, last=0);
  - (0x280, len 13, first=0, last=1).
- Single line: addr=0x100, len=15, INCR -> one descriptor (0x100, len 15, first=1, last=1); busy_o high for exactly one cycle with desc_ready_i=1.
- FIXED: addr=0x1F8, len=7, FIXED -> one descriptor (0x1F8, len 7, last=1); no split.
- Back-to-back: second Ax presented during the final handshake of the first -> ax_ready_o=1 that cycle; the next cycle shows the second transaction with first=1 and no idle bubble.
- Backpressure: desc_ready_i toggled randomly -> desc_* outputs bit-stable while stalled; descriptor sequence identical to the no-stall run.
- Reset mid-split: assert rst_i during the second descriptor of the first scenario -> next cycle desc_valid_o=0, ax_ready_o=1, busy_o=0; a new Ax is accepted normally.

Source files
------------

// File: rtl/axi_llc_pkg.sv
// Shared definitions for the LLC Ax-channel splitter.
//   - AXI burst encodings
//   - descriptor field widths for the default configuration
//   - ax_split_desc_t: one per-cache-line descriptor
//   - split_state_e: splitter FSM states
package axi_llc_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int unsigned DESC_ADDR_W  = 64;
  localparam int unsigned DESC_ID_W    = 6;
  localparam int unsigned DESC_USER_W  = 4;
  localparam int unsigned DESC_LEN_W   = 8;
  localparam int unsigned DESC_SIZE_W  = 3;
  localparam int unsigned DESC_BURST_W = 2;

  typedef struct packed {
    logic [DESC_ID_W-1:0]    id;
    logic [DESC_ADDR_W-1:0]  addr;
    logic [DESC_LEN_W-1:0]   len;
    logic [DESC_SIZE_W-1:0]  size;
    logic [DESC_BURST_W-1:0] burst;
    logic [DESC_USER_W-1:0]  user;
    logic                    rw;
    logic                    first;
    logic                    last;
  } ax_split_desc_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

endpackage

// File: rtl/axi_llc_line_split.sv
// Purely combinational cache-line split of one held Ax transaction.
// Ports:
//   i_addr, i_len, i_size, i_burst : current (remaining) transaction
//   o_desc_len  : beats-1 carried by the descriptor for the current line
//   o_next_addr : start of the following cache line
//   o_next_len  : beats-1 remaining after this descriptor
//   o_last      : this descriptor finishes the transaction
module axi_llc_line_split
  import axi_llc_pkg::*;
#(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned LineOffset = 7
) (
  input  logic [AddrWidth-1:0] i_addr,
  input  logic [7:0]           i_len,
  input  logic [2:0]           i_size,
  input  logic [1:0]           i_burst,
  output logic [7:0]           o_desc_len,
  output logic [AddrWidth-1:0] o_next_addr,
  output logic [7:0]           o_next_len,
  output logic                 o_last
);

  localparam logic [LineOffset:0]  LINE_BYTES  = {1'b1, {LineOffset{1'b0}}};
  localparam logic [LineOffset:0]  ONE_BYTE    = {{LineOffset{1'b0}}, 1'b1};
  localparam logic [AddrWidth-1:0] LINE_STRIDE = {{(AddrWidth-LineOffset-1){1'b0}}, LINE_BYTES};

  logic [LineOffset:0] w_bytes_on_line;
  logic [LineOffset:0] w_bytes_m1;
  logic [8:0]          w_beats_on_line;
  logic [8:0]          w_beats_m1;

  assign w_bytes_on_line = LINE_BYTES - {1'b0, i_addr[LineOffset-1:0]};
  assign w_bytes_m1      = w_bytes_on_line - ONE_BYTE;
  // Beats needed to reach the line end: ceil(bytes / 2^size).
  assign w_beats_on_line = 9'(w_bytes_m1 >> i_size) + 9'd1;
  assign w_beats_m1      = w_beats_on_line - 9'd1;

  // Only INCR bursts are split; FIXED/WRAP go out as a single descriptor.
  assign o_last      = (i_burst != BURST_INCR) || (w_beats_m1 >= {1'b0, i_len});
  assign o_desc_len  = o_last ? i_len : w_beats_m1[7:0];
  // Only meaningful when o_last=0, where beats_on_line <= len fits 8 bits.
  assign o_next_len  = i_len - w_beats_on_line[7:0];
  assign o_next_addr = {i_addr[AddrWidth-1:LineOffset], {LineOffset{1'b0}}} + LINE_STRIDE;

endmodule

// File: rtl/axi_llc_ax_splitter.sv
// Sequential Ax-channel splitter: holds one AW/AR transaction and emits one
// per-cache-line descriptor per accepted handshake.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   ax_*                     : incoming AXI Ax channel (valid/ready)
//   desc_*                   : outgoing line descriptors (valid/ready)
//   busy_o                   : a transaction is currently held
//
// state    | meaning
// ST_IDLE  | no transaction held, ax_ready_o=1
// ST_SPLIT | transaction held, descriptor for current line on desc_*
module axi_llc_ax_splitter
  import axi_llc_pkg::*;
#(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned IdWidth    = 6,
  parameter int unsigned UserWidth  = 4,
  parameter int unsigned LineOffset = 7,
  parameter logic        Write      = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ax_valid_i,
  output logic                 ax_ready_o,
  input  logic [IdWidth-1:0]   ax_id_i,
  input  logic [AddrWidth-1:0] ax_addr_i,
  input  logic [7:0]           ax_len_i,
  input  logic [2:0]           ax_size_i,
  input  logic [1:0]           ax_burst_i,
  input  logic [UserWidth-1:0] ax_user_i,
  output logic                 desc_valid_o,
  input  logic                 desc_ready_i,
  output logic [IdWidth-1:0]   desc_id_o,
  output logic [AddrWidth-1:0] desc_addr_o,
  output logic [7:0]           desc_len_o,
  output logic [2:0]           desc_size_o,
  output logic [1:0]           desc_burst_o,
  output logic [UserWidth-1:0] desc_user_o,
  output logic                 desc_rw_o,
  output logic                 desc_first_o,
  output logic                 desc_last_o,
  output logic                 busy_o
);

  split_state_e         r_state;
  split_state_e         w_state_next;
  logic [IdWidth-1:0]   r_id;
  logic [AddrWidth-1:0] r_addr;
  logic [7:0]           r_len;
  logic [2:0]           r_size;
  logic [1:0]           r_burst;
  logic [UserWidth-1:0] r_user;
  logic                 r_first;

  logic [7:0]           w_desc_len;
  logic [AddrWidth-1:0] w_next_addr;
  logic [7:0]           w_next_len;
  logic                 w_last;
  logic                 w_desc_hs;
  logic                 w_ax_hs;

  axi_llc_line_split #(
    .AddrWidth  (AddrWidth),
    .LineOffset (LineOffset)
  ) u_line_split (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_desc_len  (w_desc_len),
    .o_next_addr (w_next_addr),
    .o_next_len  (w_next_len),
    .o_last      (w_last)
  );

  assign w_desc_hs = desc_valid_o & desc_ready_i;
  assign w_ax_hs   = ax_valid_i & ax_ready_o;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (ax_valid_i) w_state_next = ST_SPLIT;
      // A new Ax accepted alongside the final handshake keeps us in SPLIT.
      ST_SPLIT: if (w_desc_hs && w_last && !ax_valid_i) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ax_ready_o   = 1'b0;
    desc_valid_o = 1'b0;
    busy_o       = 1'b0;
    case (r_state)
      ST_IDLE: ax_ready_o = 1'b1;
      ST_SPLIT: begin
        desc_valid_o = 1'b1;
        busy_o       = 1'b1;
        ax_ready_o   = desc_ready_i & w_last;
      end
      default: ax_ready_o = 1'b0;
    endcase
  end

  // Held transaction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_user  <= '0;
      r_first <= 1'b0;
    end else if (w_ax_hs) begin
      r_id    <= ax_id_i;
      r_addr  <= ax_addr_i;
      r_len   <= ax_len_i;
      r_size  <= ax_size_i;
      r_burst <= ax_burst_i;
      r_user  <= ax_user_i;
      r_first <= 1'b1;
    end else if (w_desc_hs && !w_last) begin
      r_addr  <= w_next_addr;
      r_len   <= w_next_len;
      r_first <= 1'b0;
    end
  end

  assign desc_id_o    = r_id;
  assign desc_addr_o  = r_addr;
  assign desc_len_o   = w_desc_len;
  assign desc_size_o  = r_size;
  assign desc_burst_o = r_burst;
  assign desc_user_o  = r_user;
  assign desc_rw_o    = Write;
  assign desc_first_o = r_first;
  assign desc_last_o  = w_last;

`ifndef SYNTHESIS
  // INCR bursts crossing the top of the address space break the 4 KiB rule.
  a_no_addr_wrap: assert property (@(posedge clk_i) disable iff (rst_i)
    (desc_valid_o && !w_last) |-> (w_next_addr > r_addr));

  a_desc_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (desc_valid_o && !desc_ready_i) |=>
      (desc_valid_o && $stable(desc_addr_o) && $stable(desc_len_o) &&
       $stable(desc_id_o) && $stable(desc_first_o) && $stable(desc_last_o)));
`endif

endmodule

// File: tb/tb_axi_llc_ax_splitter.sv
module tb_axi_llc_ax_splitter;

  localparam int LINE = 128;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  id;
    logic [3:0]  user;
  } txn_t;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  id;
    logic [3:0]  user;
    logic        first;
    logic        last;
  } desc_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ax_valid_i = 1'b0;
  logic        ax_ready_o;
  logic [5:0]  ax_id_i = '0;
  logic [63:0] ax_addr_i = '0;
  logic [7:0]  ax_len_i = '0;
  logic [2:0]  ax_size_i = '0;
  logic [1:0]  ax_burst_i = '0;
  logic [3:0]  ax_user_i = '0;
  logic        desc_valid_o;
  logic        desc_ready_i = 1'b0;
  logic [5:0]  desc_id_o;
  logic [63:0] desc_addr_o;
  logic [7:0]  desc_len_o;
  logic [2:0]  desc_size_o;
  logic [1:0]  desc_burst_o;
  logic [3:0]  desc_user_o;
  logic        desc_rw_o;
  logic        desc_first_o;
  logic        desc_last_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  txn_t  txn_q[$];
  desc_t exp_q[$];

  axi_llc_ax_splitter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ax_valid_i   (ax_valid_i),
    .ax_ready_o   (ax_ready_o),
    .ax_id_i      (ax_id_i),
    .ax_addr_i    (ax_addr_i),
    .ax_len_i     (ax_len_i),
    .ax_size_i    (ax_size_i),
    .ax_burst_i   (ax_burst_i),
    .ax_user_i    (ax_user_i),
    .desc_valid_o (desc_valid_o),
    .desc_ready_i (desc_ready_i),
    .desc_id_o    (desc_id_o),
    .desc_addr_o  (desc_addr_o),
    .desc_len_o   (desc_len_o),
    .desc_size_o  (desc_size_o),
    .desc_burst_o (desc_burst_o),
    .desc_user_o  (desc_user_o),
    .desc_rw_o    (desc_rw_o),
    .desc_first_o (desc_first_o),
    .desc_last_o  (desc_last_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: walk the burst line by line; each line carries
  // ceil(bytes_to_line_end / 2^size) beats, capped by the beats remaining.
  task automatic model_push(input txn_t t);
    longint unsigned a;
    longint unsigned line_end;
    int rem, beats, take;
    bit first;
    desc_t d;
    d.size = t.size; d.burst = t.burst; d.id = t.id; d.user = t.user;
    if (t.burst != 2'b01) begin
      d.addr = t.addr; d.len = t.len; d.first = 1'b1; d.last = 1'b1;
      exp_q.push_back(d);
      return;
    end
    a = t.addr; rem = int'(t.len) + 1; first = 1'b1;
    while (rem > 0) begin
      line_end = (a / LINE + 1) * LINE;
      beats = int'((line_end - a + (64'd1 << t.size) - 1) >> t.size);
      take = (beats < rem) ? beats : rem;
      rem -= take;
      d.addr = a; d.len = 8'(take - 1); d.first = first; d.last = (rem == 0);
      exp_q.push_back(d);
      first = 1'b0;
      a = line_end;
    end
  endtask

  // Drives everything in txn_q through the DUT and checks every cycle.
  task automatic run_list(input bit rand_ready, input bit rand_valid);
    int  budget;
    bit  hold, exp_valid, hs, exp_ax_ready;
    desc_t e;
    budget = 0; hold = 1'b0;
    while ((txn_q.size() != 0 || exp_q.size() != 0) && budget < 20000) begin
      budget++;
      @(posedge clk_i); #1;
      if (txn_q.size() != 0 && (hold || !rand_valid || ($urandom_range(0, 1) == 1))) begin
        ax_valid_i = 1'b1;
        ax_addr_i = txn_q[0].addr; ax_len_i = txn_q[0].len; ax_size_i = txn_q[0].size;
        ax_burst_i = txn_q[0].burst; ax_id_i = txn_q[0].id; ax_user_i = txn_q[0].user;
      end else begin
        ax_valid_i = 1'b0;
      end
      desc_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      exp_valid = (exp_q.size() != 0);
      hs = exp_valid && desc_ready_i;
      exp_ax_ready = !exp_valid || (hs && exp_q[0].last);
      chk("desc_valid", 64'(desc_valid_o), 64'(exp_valid));
      chk("busy", 64'(busy_o), 64'(exp_valid));
      chk("ax_ready", 64'(ax_ready_o), 64'(exp_ax_ready));
      if (exp_valid && desc_valid_o) begin
        e = exp_q[0];
        chk("addr", desc_addr_o, e.addr);
        chk("len", 64'(desc_len_o), 64'(e.len));
        chk("first", 64'(desc_first_o), 64'(e.first));
        chk("last", 64'(desc_last_o), 64'(e.last));
        chk("id", 64'(desc_id_o), 64'(e.id));
        chk("user", 64'(desc_user_o), 64'(e.user));
        chk("size", 64'(desc_size_o), 64'(e.size));
        chk("burst", 64'(desc_burst_o), 64'(e.burst));
        chk("rw", 64'(desc_rw_o), 64'd0);
      end
      if (hs) void'(exp_q.pop_front());
      if (ax_valid_i && exp_ax_ready) begin
        model_push(txn_q.pop_front());
        hold = 1'b0;
      end else begin
        hold = ax_valid_i;
      end
    end
    if (budget >= 20000) begin
      chk("timeout", 64'd1, 64'd0);
      txn_q.delete();
      exp_q.delete();
    end
    @(posedge clk_i); #1;
    ax_valid_i = 1'b0;
  endtask

  function automatic txn_t mk(input logic [63:0] a, input logic [7:0] l,
                              input logic [2:0] s, input logic [1:0] b);
    txn_t t;
    t.addr = a; t.len = l; t.size = s; t.burst = b;
    t.id = 6'($urandom); t.user = 4'($urandom);
    return t;
  endfunction

  initial begin
    txn_t t;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(desc_valid_o), 64'd0);
    chk("rst_ready", 64'(ax_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_addr", desc_addr_o, 64'd0);
    chk("rst_len", 64'(desc_len_o), 64'd0);
    rst_i = 1'b0;

    // Directed, full-rate consumer.
    txn_q.push_back(mk(64'h1F0, 8'd31, 3'd3, 2'b01)); run_list(1'b0, 1'b0);
    txn_q.push_back(mk(64'h100, 8'd15, 3'd3, 2'b01)); run_list(1'b0, 1'b0);
    txn_q.push_back(mk(64'h1F8, 8'd7, 3'd3, 2'b00));  run_list(1'b0, 1'b0);

    // Back-to-back: second Ax waits on the final handshake of the first.
    txn_q.push_back(mk(64'h1F0, 8'd31, 3'd3, 2'b01));
    txn_q.push_back(mk(64'h100, 8'd15, 3'd3, 2'b01));
    txn_q.push_back(mk(64'h1F8, 8'd7, 3'd3, 2'b10));
    run_list(1'b0, 1'b0);

    // Same set under random backpressure.
    txn_q.push_back(mk(64'h1F0, 8'd31, 3'd3, 2'b01));
    txn_q.push_back(mk(64'h100, 8'd15, 3'd3, 2'b01));
    txn_q.push_back(mk(64'h1F8, 8'd7, 3'd3, 2'b00));
    run_list(1'b1, 1'b0);

    // Reset during the second descriptor of the line-crossing burst.
    @(posedge clk_i); #1;
    t = mk(64'h1F0, 8'd31, 3'd3, 2'b01);
    ax_valid_i = 1'b1; ax_addr_i = t.addr; ax_len_i = t.len;
    ax_size_i = t.size; ax_burst_i = t.burst; desc_ready_i = 1'b1;
    @(posedge clk_i); #1;
    ax_valid_i = 1'b0; #1;
    chk("mid_first_addr", desc_addr_o, 64'h1F0);
    @(posedge clk_i); #1; #1;
    chk("mid_second_addr", desc_addr_o, 64'h200);
    chk("mid_second_len", 64'(desc_len_o), 64'd15);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; #1;
    chk("post_rst_valid", 64'(desc_valid_o), 64'd0);
    chk("post_rst_ready", 64'(ax_ready_o), 64'd1);
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    txn_q.push_back(mk(64'h380, 8'd20, 3'd2, 2'b01)); run_list(1'b0, 1'b0);

    // Random traffic, random valid gaps and backpressure.
    for (int i = 0; i < 60; i++) begin
      txn_q.push_back(mk(64'($urandom_range(0, 32'hFFFFF)), 8'($urandom),
                         3'($urandom), 2'($urandom_range(0, 3))));
    end
    run_list(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
